axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Packet-aware round-robin arbiter sharing one AXI4-Stream output between NUM_SRC upstream requesters.
- Grant locks to one source from its first beat until its tlast beat transfers; the next grant goes to the next requester after the last winner.
- Output is registered (one-entry buffer). m_axis_tid carries the winning source index so the downstream sink can demultiplex.

Parameters:
- NUM_SRC, 4, number of requesting stream sources; legal range 2..16.
- DATA_WIDTH, 8, tdata width per source in bits; multiple of 8.
- TIMEOUT, 16, stall-cycle limit for the watchdog; used only with ARB_TIMEOUT_EN; legal range 2..65535.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  NUM_SRC*DATA_WIDTH  source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  input  NUM_SRC  per-source valid.
- s_axis_tlast  input  NUM_SRC  per-source end of packet.
- s_axis_tready  output  NUM_SRC  per-source ready; at most one bit high at any time.
- m_axis_tdata  output  DATA_WIDTH  arbitrated data.
- m_axis_tvalid  output  1  output valid.
- m_axis_tlast  output  1  output end of packet.
- m_axis_tid  output  8  index of the source that produced the beat, zero-extended.
- m_axis_tready  input  1  downstream ready.
- timeout_err  output  1  one-cycle pulse on watchdog release; present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, grant=0, last_grant=NUM_SRC-1 (source 0 wins first), m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, s_axis_tready=0, timeout_err=0.
- Reset mid-packet: the output register and any partial packet are dropped; nothing is replayed after reset.
- IDLE state:
  - s_axis_tready is all zero.
  - If any s_axis_tvalid is high, grant takes the first valid index searching upward from last_grant+1, modulo NUM_SRC. Next state is BUSY.
  - If no s_axis_tvalid is high, the state stays IDLE.
- BUSY state:
  - s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready. All other ready bits are 0.
  - A beat transfers when s_axis_tvalid[grant] && s_axis_tready[grant]. On transfer, the output register loads tdata, tlast and tid=grant, and m_axis_tvalid is set.
  - A transfer with s_axis_tlast[grant]=1 sets last_grant=grant. Next state is IDLE.
- Output register:
  - m_axis_tvalid clears when m_axis_tready=1 and no new beat loads in the same cycle.
  - Output data, tlast and tid are held stable while m_axis_tvalid=1 && m_axis_tready=0.
  - Simultaneous output drain and input load in one cycle keeps m_axis_tvalid=1 with the new beat; full throughput is 1 beat/cycle.
- Latency:
  - The arbitration decision takes 1 cycle. A valid asserted in IDLE at cycle N transfers at the end of cycle N+1 and appears on m_axis in cycle N+2.
  - There is one bubble cycle between packets while re-arbitrating.
- Requester behaviour:
  - Non-granted sources are never acked. Their tvalid may stay high indefinitely.
  - A single requester with back-to-back packets is re-granted after each one-cycle IDLE.
- Wrap-around: the search moves from index NUM_SRC-1 to index 0.
- Single-beat packet (tlast on the first beat): legal. The source occupies BUSY for one transfer cycle.
- A granted source dropping tvalid mid-packet keeps the grant; BUSY waits.

Optional Feature:
- Macro name: ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit stall counter runs in BUSY. It increments each cycle that s_axis_tvalid[grant]=0, and clears on any transfer and on entry to BUSY.
  - When the counter reaches TIMEOUT, the state is forced to IDLE and last_grant=grant.
  - timeout_err pulses high for 1 cycle at that point. No tlast is synthesised on m_axis.
- Without the macro: the counter and the timeout_err port are absent, and the grant is held indefinitely until tlast.

Test Plan:
- Single source: src1 sends a 3-beat packet (0xA1,0xA2,0xA3, tlast on 0xA3), m_axis_tready=1 -> first beat on m_axis 2 cycles after tvalid, beats on consecutive cycles, tid=1, tlast only on 0xA3.
- Fairness: all 4 sources hold tvalid continuously, each sending 2-beat packets -> grant order 0,1,2,3,0; exactly 1 idle cycle between packets; no interleaving of beats.
- Backpressure: m_axis_tready toggling 1,0,0,1 during a 4-beat packet from src2 -> m_axis_tdata stable while stalled, all 4 beats delivered in order, at most one s_axis_tready bit high in any cycle.
- Mid-packet reset: rst driven low during beat 2 of 4 from src3 -> all outputs 0 at once; after release, src0 wins first if requesting.
- Mid-packet gap: src0 drops tvalid for 5 cycles mid-packet while src1 is requesting -> src1 not granted until src0's tlast; without the macro, run the same with a 20-cycle gap (longer than TIMEOUT) and the grant is still held.
- ARB_TIMEOUT_EN, TIMEOUT=16: src0 stalls 16 cycles mid-packet -> timeout_err pulses once, next grant is src1, src0's further beats wait for a fresh grant.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-aware round-robin AXI4-Stream arbiter, registered output.
// Optional stall watchdog with timeout_err port is built when ARB_TIMEOUT_EN is defined.
module axis_rr_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   output logic [7:0]                    m_axis_tid,
   input  logic                          m_axis_tready
`ifdef ARB_TIMEOUT_EN
   ,
   output logic                          timeout_err
`endif
);

   localparam int IW = $clog2(NUM_SRC);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t                state;
   logic [IW-1:0]         grant;
   logic [IW-1:0]         last_grant;
   logic [IW-1:0]         pick;
   logic [IW-1:0]         cand;
   logic                  found;
   logic                  any_req;
   logic                  accept;
   logic                  fire;
   logic                  fire_last;
   logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);
   logic [15:0] stall_cnt;
`endif

   if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
      $error("NUM_SRC must be in 2..16");
   end
   if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $error("DATA_WIDTH must be a non-zero multiple of 8");
   end
   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("TIMEOUT must be in 2..65535");
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_split
      assign src_data[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign any_req   = |s_axis_tvalid;
   assign accept    = !m_axis_tvalid || m_axis_tready;
   assign fire      = (state == BUSY) && s_axis_tvalid[grant] && accept;
   assign fire_last = fire && s_axis_tlast[grant];

   // First requester strictly after the previous winner, wrapping at NUM_SRC.
   always_comb begin
      pick  = last_grant;
      cand  = last_grant;
      found = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = IW'((int'(last_grant) + k) % NUM_SRC);
         if (!found && s_axis_tvalid[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      s_axis_tready = '0;
      if (state == BUSY) begin
         s_axis_tready[grant] = accept;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         grant         <= '0;
         last_grant    <= IW'(NUM_SRC - 1);
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tid    <= '0;
`ifdef ARB_TIMEOUT_EN
         stall_cnt     <= '0;
         timeout_err   <= 1'b0;
`endif
      end else begin
         if (fire) begin
            m_axis_tdata  <= src_data[grant];
            m_axis_tlast  <= s_axis_tlast[grant];
            m_axis_tid    <= 8'(grant);
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

`ifdef ARB_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif

         unique case (state)
            IDLE: begin
               if (any_req) begin
                  grant <= pick;
                  state <= BUSY;
`ifdef ARB_TIMEOUT_EN
                  stall_cnt <= '0;
`endif
               end
            end
            BUSY: begin
               if (fire_last) begin
                  last_grant <= grant;
                  state      <= IDLE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (fire) begin
                  stall_cnt <= '0;
               end else if (!s_axis_tvalid[grant]) begin
                  // Give up on a silent owner; no tlast is forged downstream.
                  if (stall_cnt == STALL_LAST) begin
                     stall_cnt   <= '0;
                     last_grant  <= grant;
                     state       <= IDLE;
                     timeout_err <= 1'b1;
                  end else begin
                     stall_cnt <= stall_cnt + 16'd1;
                  end
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed and randomized checks of axis_rr_arbiter
// against a packet-level round-robin reference model.
module tb_axis_rr_arbiter;

   localparam int NS = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NS*DW-1:0] s_axis_tdata = '0;
   logic [NS-1:0] s_axis_tvalid = '0;
   logic [NS-1:0] s_axis_tlast = '0;
   logic [NS-1:0] s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic [7:0]    m_axis_tid;
   logic          m_axis_tready = 1'b0;
`ifdef ARB_TIMEOUT_EN
   logic          timeout_err;
`endif

   always #5 clk = ~clk;

   axis_rr_arbiter #(
      .NUM_SRC(NS),
      .DATA_WIDTH(DW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_tid(m_axis_tid),
      .m_axis_tready(m_axis_tready)
`ifdef ARB_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Per-source beat queues: {tlast, tdata}, plus idle cycles before each beat.
   logic [DW:0] mem [NS][64];
   int          gapb [NS][64];
   int          head [NS];
   int          tail [NS];

   logic [DW-1:0] o_data [256];
   logic          o_last [256];
   logic [7:0]    o_tid  [256];
   int            o_cyc  [256];
   int            n_out;

   logic [DW-1:0] e_data [256];
   logic          e_last [256];
   int            e_tid  [256];
   int            n_exp;

   int       tr_mode = 0;
   logic [3:0] tr_pat = 4'b1001;
   int       to_pulses;
   logic     pv;
   logic     pl;
   logic [DW-1:0] pd;
   logic [7:0] pt;

   task automatic push(input int s, input logic [DW-1:0] d,
                       input logic l, input int g);
      mem[s][tail[s]]  = {l, d};
      gapb[s][tail[s]] = g;
      tail[s]++;
   endtask

   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         logic v;
         logic [DW:0] b;
         v = 1'b0;
         b = '0;
         if (head[i] < tail[i]) begin
            b = mem[i][head[i]];
            if (gapb[i][head[i]] > 0) gapb[i][head[i]]--;
            else v = 1'b1;
         end
         s_axis_tvalid[i]          = v;
         s_axis_tlast[i]           = b[DW];
         s_axis_tdata[i*DW +: DW]  = b[DW-1:0];
      end
      case (tr_mode)
         0: m_axis_tready = 1'b1;
         1: m_axis_tready = ($urandom_range(0, 3) != 0);
         default: m_axis_tready = tr_pat[cyc % 4];
      endcase
   endtask

   task automatic tick();
      logic [NS-1:0] sf;
      logic mf;
      checks++;
      if ($countones(s_axis_tready) > 1) begin
         errors++;
         $display("FAIL ready_onehot cyc %0d got %b want at most one bit",
                  cyc, s_axis_tready);
      end
      if (pv) begin
         checks++;
         if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid}
             !== {1'b1, pl, pd, pt}) begin
            errors++;
            $display("FAIL hold_stable cyc %0d got v%b d%h t%0d want v1 d%h t%0d",
                     cyc, m_axis_tvalid, m_axis_tdata, m_axis_tid, pd, pt);
         end
      end
      pv = m_axis_tvalid && !m_axis_tready;
      pl = m_axis_tlast;
      pd = m_axis_tdata;
      pt = m_axis_tid;
`ifdef ARB_TIMEOUT_EN
      if (timeout_err === 1'b1) to_pulses++;
`endif
      sf = s_axis_tvalid & s_axis_tready;
      mf = m_axis_tvalid && m_axis_tready;
      if (mf && n_out < 256) begin
         o_data[n_out] = m_axis_tdata;
         o_last[n_out] = m_axis_tlast;
         o_tid[n_out]  = m_axis_tid;
         o_cyc[n_out]  = cyc;
         n_out++;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NS; i++) if (sf[i]) head[i]++;
      drive();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int i = 0; i < NS; i++) begin
         head[i] = 0;
         tail[i] = 0;
         for (int j = 0; j < 64; j++) gapb[i][j] = 0;
      end
      n_out = 0;
      pv = 1'b0;
      to_pulses = 0;
      tr_mode = 0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
      #1;
   endtask

   task automatic test_reset();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid, s_axis_tready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v%b l%b d%h t%h r%b want all zero",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid, s_axis_tready);
      end
`ifdef ARB_TIMEOUT_EN
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout_err got %b want 0", timeout_err);
      end
`endif
      do_reset();
      repeat (3) tick();
      checks++;
      if ({m_axis_tvalid, s_axis_tready} !== '0 || n_out != 0) begin
         errors++;
         $display("FAIL idle_quiet got v%b r%b n%0d want 0 0 0",
                  m_axis_tvalid, s_axis_tready, n_out);
      end
   endtask

   task automatic test_single();
      int n0;
      do_reset();
      push(1, 8'hA1, 1'b0, 0);
      push(1, 8'hA2, 1'b0, 0);
      push(1, 8'hA3, 1'b1, 0);
      drive();
      #1;
      n0 = cyc;
      repeat (8) tick();
      checks++;
      if (n_out != 3) begin
         errors++;
         $display("FAIL single_count got %0d want 3", n_out);
      end
      for (int k = 0; k < 3 && k < n_out; k++) begin
         checks++;
         if (o_cyc[k] != n0 + 2 + k || o_tid[k] !== 8'd1 ||
             o_data[k] !== 8'(8'hA1 + k) || o_last[k] !== (k == 2)) begin
            errors++;
            $display("FAIL single_beat %0d got c%0d t%0d d%h l%b want c%0d t1 d%h l%b",
                     k, o_cyc[k] - n0, o_tid[k], o_data[k], o_last[k],
                     2 + k, 8'(8'hA1 + k), (k == 2));
         end
      end
   endtask

   task automatic test_fairness();
      int n0;
      int ord [5];
      int pk [5];
      ord = '{0, 1, 2, 3, 0};
      pk  = '{0, 0, 0, 0, 1};
      do_reset();
      for (int s = 0; s < NS; s++) begin
         for (int p = 0; p < ((s == 0) ? 2 : 1); p++) begin
            for (int b = 0; b < 2; b++) push(s, 8'(s*16 + p*4 + b), b == 1, 0);
         end
      end
      drive();
      #1;
      n0 = cyc;
      repeat (25) tick();
      checks++;
      if (n_out != 10) begin
         errors++;
         $display("FAIL fair_count got %0d want 10", n_out);
      end
      for (int k = 0; k < 10 && k < n_out; k++) begin
         int j;
         int b;
         j = k / 2;
         b = k % 2;
         checks++;
         if (o_tid[k] !== 8'(ord[j]) || o_data[k] !== 8'(ord[j]*16 + pk[j]*4 + b) ||
             o_last[k] !== (b == 1) || o_cyc[k] != n0 + 2 + 3*j + b) begin
            errors++;
            $display("FAIL fair_beat %0d got t%0d d%h c%0d want t%0d d%h c%0d",
                     k, o_tid[k], o_data[k], o_cyc[k] - n0, ord[j],
                     8'(ord[j]*16 + pk[j]*4 + b), 2 + 3*j + b);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      tr_mode = 2;
      for (int b = 0; b < 4; b++) push(2, 8'(8'h20 + b), b == 3, 0);
      drive();
      #1;
      for (int t = 0; t < 40 && n_out < 4; t++) tick();
      checks++;
      if (n_out != 4) begin
         errors++;
         $display("FAIL bp_count got %0d want 4", n_out);
      end
      for (int k = 0; k < 4 && k < n_out; k++) begin
         checks++;
         if (o_tid[k] !== 8'd2 || o_data[k] !== 8'(8'h20 + k) || o_last[k] !== (k == 3)) begin
            errors++;
            $display("FAIL bp_beat %0d got t%0d d%h l%b want t2 d%h l%b",
                     k, o_tid[k], o_data[k], o_last[k], 8'(8'h20 + k), (k == 3));
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int b = 0; b < 4; b++) push(3, 8'(8'h40 + b), b == 3, 0);
      drive();
      #1;
      for (int t = 0; t < 20 && head[3] < 2; t++) tick();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid, s_axis_tready} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got v%b l%b d%h t%h r%b want all zero",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid, s_axis_tready);
      end
      do_reset();
      push(3, 8'h33, 1'b1, 0);
      push(0, 8'h30, 1'b1, 0);
      drive();
      #1;
      repeat (10) tick();
      checks++;
      if (n_out != 2 || o_tid[0] !== 8'd0 || o_data[0] !== 8'h30 ||
          o_tid[1] !== 8'd3 || o_data[1] !== 8'h33) begin
         errors++;
         $display("FAIL midreset_order got n%0d t%0d d%h t%0d d%h want n2 t0 d30 t3 d33",
                  n_out, o_tid[0], o_data[0], o_tid[1], o_data[1]);
      end
   endtask

   task automatic test_gap(input int g);
      do_reset();
      for (int b = 0; b < 4; b++) push(0, 8'(8'h50 + b), b == 3, (b == 1) ? g : 0);
      push(1, 8'h61, 1'b1, 0);
      drive();
      #1;
      for (int t = 0; t < g + 30 && n_out < 5; t++) tick();
      checks++;
      if (n_out != 5) begin
         errors++;
         $display("FAIL gap%0d_count got %0d want 5", g, n_out);
      end
      for (int k = 0; k < 5 && k < n_out; k++) begin
         logic [7:0] wd;
         int wt;
         wd = (k < 4) ? 8'(8'h50 + k) : 8'h61;
         wt = (k < 4) ? 0 : 1;
         checks++;
         if (o_tid[k] !== 8'(wt) || o_data[k] !== wd) begin
            errors++;
            $display("FAIL gap%0d_beat %0d got t%0d d%h want t%0d d%h",
                     g, k, o_tid[k], o_data[k], wt, wd);
         end
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int wt [4];
      logic [7:0] wd [4];
      wt = '{0, 1, 0, 0};
      wd = '{8'h70, 8'h81, 8'h71, 8'h72};
      do_reset();
      for (int b = 0; b < 3; b++) push(0, 8'(8'h70 + b), b == 2, (b == 1) ? TO : 0);
      push(1, 8'h81, 1'b1, 0);
      drive();
      #1;
      for (int t = 0; t < 60 && n_out < 4; t++) tick();
      repeat (4) tick();
      checks++;
      if (to_pulses != 1) begin
         errors++;
         $display("FAIL timeout_pulses got %0d want 1", to_pulses);
      end
      checks++;
      if (n_out != 4) begin
         errors++;
         $display("FAIL timeout_count got %0d want 4", n_out);
      end
      for (int k = 0; k < 4 && k < n_out; k++) begin
         checks++;
         if (o_tid[k] !== 8'(wt[k]) || o_data[k] !== wd[k]) begin
            errors++;
            $display("FAIL timeout_beat %0d got t%0d d%h want t%0d d%h",
                     k, o_tid[k], o_data[k], wt[k], wd[k]);
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         int rem [NS];
         int ep [NS];
         int left;
         int last;
         do_reset();
         tr_mode = 1;
         left = 0;
         for (int s = 0; s < NS; s++) begin
            int np;
            np = $urandom_range(1, 3);
            rem[s] = np;
            ep[s] = 0;
            left += np;
            for (int p = 0; p < np; p++) begin
               int len;
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) begin
                  push(s, 8'($urandom), b == len - 1,
                       (b > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
               end
            end
         end
         // Whole packets in round-robin order among sources with packets left.
         n_exp = 0;
         last = NS - 1;
         while (left > 0) begin
            int s;
            logic done;
            s = last;
            done = 1'b0;
            for (int k = 1; k <= NS; k++) begin
               int c;
               c = (last + k) % NS;
               if (!done && rem[c] > 0) begin
                  s = c;
                  done = 1'b1;
               end
            end
            done = 1'b0;
            while (!done) begin
               e_data[n_exp] = mem[s][ep[s]][DW-1:0];
               e_last[n_exp] = mem[s][ep[s]][DW];
               e_tid[n_exp]  = s;
               done = mem[s][ep[s]][DW];
               n_exp++;
               ep[s]++;
            end
            rem[s]--;
            left--;
            last = s;
         end
         drive();
         #1;
         for (int t = 0; t < 800 && n_out < n_exp; t++) tick();
         checks++;
         if (n_out != n_exp) begin
            errors++;
            $display("FAIL rand%0d_count got %0d want %0d", r, n_out, n_exp);
         end
         for (int k = 0; k < n_exp && k < n_out; k++) begin
            checks++;
            if (o_tid[k] !== 8'(e_tid[k]) || o_data[k] !== e_data[k] ||
                o_last[k] !== e_last[k]) begin
               errors++;
               $display("FAIL rand%0d_beat %0d got t%0d d%h l%b want t%0d d%h l%b",
                        r, k, o_tid[k], o_data[k], o_last[k],
                        e_tid[k], e_data[k], e_last[k]);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      n_out = 0;
      pv = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_mid_reset();
      test_gap(5);
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_gap(20);
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
